// File: rtl/grant_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// grant_scheduler_pkg
// Shared definitions for the round-robin grant scheduler:
//   - state_e     : arbiter FSM states (IDLE, BUSY, RELEASE)
//   - IDX_W/VEC_W : width of the binary grant index and of the request vector
//   - CNT_W       : width of the saturating hold counter
//   - valid_mask  : mask of the requester bits that take part in arbitration
// -----------------------------------------------------------------------------
package grant_scheduler_pkg;

  localparam int IDX_W = 4;
  localparam int VEC_W = 16;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Bits 0..n-1 set; requesters at index n and above never compete.
  function automatic logic [VEC_W-1:0] valid_mask(input int n);
    logic [VEC_W-1:0] m;
    m = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/grant_scheduler_if.sv
// -----------------------------------------------------------------------------
// grant_scheduler_if
// Request/grant bundle between the requesting blocks and the scheduler.
//   enable    : requester side -> scheduler, allows new grants
//   req       : per-requester request levels
//   done      : single-cycle release pulse from the current owner
//   gnt       : one-hot grant
//   gnt_idx   : binary index of the granted requester
//   gnt_valid : a grant is held
//   timeout   : one-cycle pulse when a grant is force-released
//   hold_cnt  : cycles the current grant has been held (saturating)
// modport master : requester side; modport slave : scheduler side.
// -----------------------------------------------------------------------------
interface grant_scheduler_if;
  import grant_scheduler_pkg::*;

  logic             enable;
  logic [VEC_W-1:0] req;
  logic             done;
  logic [VEC_W-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output enable, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout, hold_cnt
  );

  modport slave (
    input  enable, req, done,
    output gnt, gnt_idx, gnt_valid, timeout, hold_cnt
  );

endinterface

// File: rtl/grant_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// grant_scheduler_rr_pick
// Purely combinational rotate-priority picker.
//   req      : raw request vector (bits >= N are masked off here)
//   ptr      : index where the upward search starts (always < N)
//   pick_oh  : one-hot winner, zero when nothing is requested
//   pick_idx : binary index of the winner
//   any      : at least one eligible request
// The masked vector is rotated right by ptr so the search start lands on
// bit 0, the lowest set bit is isolated, and the result is rotated back.
// Rotating over the full 16-bit ring is equivalent to wrapping at N-1
// because every bit at N and above is already cleared by the mask.
// -----------------------------------------------------------------------------
module grant_scheduler_rr_pick
  import grant_scheduler_pkg::*;
#(
  parameter int N = 10
) (
  input  logic [VEC_W-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [VEC_W-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [VEC_W-1:0] masked;
  logic [VEC_W-1:0] rot;
  logic [VEC_W-1:0] low;
  logic [IDX_W-1:0] off;

  assign masked = req & valid_mask(N);
  assign any    = |masked;

  genvar gi;
  generate
    for (gi = 0; gi < VEC_W; gi++) begin : g_rotate
      logic [IDX_W-1:0] src_fwd;
      logic [IDX_W-1:0] src_back;
      // Index arithmetic wraps modulo 16 through the 4-bit width.
      assign src_fwd     = IDX_W'(gi) + ptr;
      assign src_back    = IDX_W'(gi) - ptr;
      assign rot[gi]     = masked[src_fwd];
      assign pick_oh[gi] = low[src_back];
    end
  endgenerate

  // Two's-complement trick isolates the lowest set bit of the rotated vector.
  assign low = rot & (~rot + VEC_W'(1));

  // Descending scan so the final assignment is the lowest set bit.
  always_comb begin
    off = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign pick_idx = off + ptr;

endmodule

// File: rtl/grant_scheduler.sv
// -----------------------------------------------------------------------------
// grant_scheduler
// Round-robin arbiter sharing one 16-way resource between up to N requesters.
// Holds a single registered grant until the owner releases it (done pulse or
// dropping its own req bit) or, when MAX_HOLD is non-zero, until the hold
// limit expires, in which case timeout pulses for one cycle.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high; clears every output on the next edge
//   bus   : grant_scheduler_if.slave (enable/req/done in, grant outputs out)
// Every output comes straight from a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module grant_scheduler
  import grant_scheduler_pkg::*;
#(
  parameter int N        = 10,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               reset,
  grant_scheduler_if.slave   bus
);

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;
  logic [VEC_W-1:0] gnt_q,       gnt_d;
  logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q,   timeout_d;
  logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;

  logic [VEC_W-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             grant_try;
  logic             owner_gone;
  logic             expire;

  grant_scheduler_rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    grant_try   = 1'b0;
    owner_gone  = 1'b0;
    expire      = 1'b0;

    case (state_q)
      IDLE: begin
        grant_try = 1'b1;
      end

      BUSY: begin
        hold_cnt_d = (hold_cnt_q == {CNT_W{1'b1}}) ? hold_cnt_q
                                                   : hold_cnt_q + CNT_W'(1);
        // A dropped owner request is an implicit release.
        owner_gone = bus.done || ((bus.req & gnt_q) == '0);
        expire     = (MAX_HOLD != 0) && (int'(hold_cnt_q) == MAX_HOLD - 1);
        if (owner_gone || expire) begin
          state_d     = RELEASE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          // A voluntary release in the expiry cycle is not a timeout.
          timeout_d   = expire && !owner_gone;
          ptr_d       = (gnt_idx_q == IDX_W'(N - 1)) ? '0
                                                     : gnt_idx_q + IDX_W'(1);
        end
      end

      RELEASE: begin
        // The dead cycle is already on the outputs; arbitrating here lets the
        // next grant appear one edge after the release, giving the
        // grant/done/dead three-cycle cadence.
        state_d   = IDLE;
        grant_try = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_try && bus.enable && pick_any) begin
      state_d     = BUSY;
      gnt_d       = pick_oh;
      gnt_idx_d   = pick_idx;
      gnt_valid_d = 1'b1;
      hold_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.hold_cnt  = hold_cnt_q;

endmodule
